// File: rtl/mshr_atomic_responder.sv
// mshr_atomic_responder: single-outstanding memory endpoint executing load/store/AMO
// requests against a local DEPTH x 64-bit backing store, returning the old value.
module mshr_atomic_responder #(
    parameter int DEPTH    = 16,
    parameter int ADDR_LSB = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [2:0]  mem_req_req_type,
    input  logic [7:0]  mem_req_mshrid,
    input  logic [39:0] mem_req_address,
    input  logic [1:0]  mem_req_size,
    input  logic [7:0]  mem_req_homeid,
    input  logic [7:0]  mem_req_write_mask,
    input  logic [63:0] mem_req_data_0,
    input  logic [63:0] mem_req_data_1,
    output logic        atomic_resp_valid,
    output logic [63:0] atomic_resp_data,
    output logic [7:0]  atomic_resp_mshrid,
    output logic        busy
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd2,
                           OP_SWAP = 3'd3, OP_CAS = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    type_q, type_d;
    logic [7:0]    id_q, id_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          hi_q, hi_d, w32_q, w32_d;
    logic [7:0]    wm_q, wm_d;
    logic [63:0]   d0_q, d0_d, d1_q, d1_d, old_q, old_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [7:0]    rid_q, rid_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];

    logic [63:0] old_op, d0_op, res, bm, mask, wdata, new_word, rdata;
    logic        we, illegal;
    logic        unused_ok;

    assign unused_ok          = ^{mem_req_homeid, mem_req_address};
    assign mem_req_ready      = state_q == S_IDLE;
    assign busy               = state_q != S_IDLE;
    assign atomic_resp_valid  = state_q == S_RESP;
    assign atomic_resp_data   = rdata_q;
    assign atomic_resp_mshrid = rid_q;

    // Operands are narrowed to the selected half in 32-bit mode, then merged back via mask.
    always_comb begin
        old_op  = w32_q ? {32'h0, hi_q ? old_q[63:32] : old_q[31:0]} : old_q;
        d0_op   = w32_q ? {32'h0, d0_q[31:0]} : d0_q;
        illegal = type_q > OP_CAS;
        res     = type_q == OP_ADD ? old_op + d0_op : type_q == OP_CAS ? d1_q : d0_q;
        we      = type_q == OP_STORE || type_q == OP_ADD || type_q == OP_SWAP ||
                  (type_q == OP_CAS && old_op == d0_op);
        bm      = '0;
        for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{wm_q[i]}};
        mask    = type_q == OP_STORE
                ? (w32_q ? (hi_q ? {bm[31:0], 32'h0} : {32'h0, bm[31:0]}) : bm)
                : (w32_q ? (hi_q ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF}) : '1);
        wdata    = w32_q ? {res[31:0], res[31:0]} : res;
        new_word = (old_q & ~mask) | (wdata & mask);
        rdata    = illegal ? '1 : type_q == OP_STORE ? '0 : old_op;
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        id_d    = id_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        w32_d   = w32_q;
        wm_d    = wm_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: if (mem_req_valid) begin
                type_d  = mem_req_req_type;
                id_d    = mem_req_mshrid;
                idx_d   = mem_req_address[ADDR_LSB +: IW];
                hi_d    = mem_req_address[2];
                w32_d   = mem_req_size == 2'b10;
                wm_d    = mem_req_write_mask;
                d0_d    = mem_req_data_0;
                d1_d    = mem_req_data_1;
                state_d = S_READ;
            end
            S_READ: begin
                old_d   = mem_q[idx_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (we) mem_d[idx_q] = new_word;
                rdata_d = rdata;
                rid_d   = id_q;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            hi_q    <= 1'b0;
            w32_q   <= 1'b0;
            wm_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            rid_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            w32_q   <= w32_d;
            wm_q    <= wm_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_mshr_atomic_responder.sv
// tb_mshr_atomic_responder: directed requests with a scoreboard of expected responses
// checked for data, mshrid and exact T+3 arrival.
module tb_mshr_atomic_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid = 1'b0;
    logic        mem_req_ready;
    logic [2:0]  mem_req_req_type = '0;
    logic [7:0]  mem_req_mshrid = '0;
    logic [39:0] mem_req_address = '0;
    logic [1:0]  mem_req_size = 2'b11;
    logic [7:0]  mem_req_homeid = '0;
    logic [7:0]  mem_req_write_mask = '0;
    logic [63:0] mem_req_data_0 = '0;
    logic [63:0] mem_req_data_1 = '0;
    logic        atomic_resp_valid;
    logic [63:0] atomic_resp_data;
    logic [7:0]  atomic_resp_mshrid;
    logic        busy;

    mshr_atomic_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_req_type(mem_req_req_type), .mem_req_mshrid(mem_req_mshrid),
        .mem_req_address(mem_req_address), .mem_req_size(mem_req_size),
        .mem_req_homeid(mem_req_homeid), .mem_req_write_mask(mem_req_write_mask),
        .mem_req_data_0(mem_req_data_0), .mem_req_data_1(mem_req_data_1),
        .atomic_resp_valid(atomic_resp_valid), .atomic_resp_data(atomic_resp_data),
        .atomic_resp_mshrid(atomic_resp_mshrid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (atomic_resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", {56'h0, atomic_resp_mshrid}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_data", atomic_resp_data, e.data);
                chk("resp_mshrid", {56'h0, atomic_resp_mshrid}, {56'h0, e.id});
                chk("resp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic req(input logic [2:0] t, input logic [7:0] id, input logic [39:0] a,
                       input logic [1:0] sz, input logic [7:0] wm, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [63:0] exp);
        int n = 0;
        @(negedge clk);
        mem_req_req_type = t; mem_req_mshrid = id; mem_req_address = a;
        mem_req_size = sz; mem_req_write_mask = wm; mem_req_data_0 = d0;
        mem_req_data_1 = d1; mem_req_homeid = id ^ 8'h5A; mem_req_valid = 1'b1;
        while (!mem_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("ready_timeout", 64'(n), 64'(0));
        else q.push_back('{id: id, data: exp, due: cyc + 3});
        @(posedge clk);
        #1 mem_req_valid = 1'b0;
        mem_req_data_0 = ~mem_req_data_0;
        mem_req_mshrid = 8'hEE;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        int last;
        int pulses;
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'h0, mem_req_ready}, 64'd1);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_valid", {63'h0, atomic_resp_valid}, 64'd0);
        chk("rst_data", atomic_resp_data, 64'd0);
        chk("rst_mshrid", {56'h0, atomic_resp_mshrid}, 64'd0);

        req(3'd0, 8'h11, 40'h28, 2'b11, 8'h00, 64'h0, 64'h0, 64'h0);
        req(3'd1, 8'h12, 40'h08, 2'b11, 8'hFF, 64'h1122334455667788, 64'h0, 64'h0);
        req(3'd0, 8'h13, 40'h08, 2'b11, 8'h00, 64'h0, 64'h0, 64'h1122334455667788);
        req(3'd1, 8'h14, 40'h08, 2'b11, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h0, 64'h0);
        req(3'd0, 8'h15, 40'h08, 2'b11, 8'h00, 64'h0, 64'h0, 64'h11223344AAAAAAAA);
        req(3'd3, 8'h16, 40'h10, 2'b11, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0);
        req(3'd2, 8'h17, 40'h10, 2'b11, 8'h00, 64'h2, 64'h0, 64'hFFFFFFFFFFFFFFFF);
        req(3'd0, 8'h18, 40'h10, 2'b11, 8'h00, 64'h0, 64'h0, 64'h1);
        req(3'd1, 8'h19, 40'h18, 2'b11, 8'hFF, 64'hFFFFFFFF00000005, 64'h0, 64'h0);
        req(3'd2, 8'h1A, 40'h1C, 2'b10, 8'h00, 64'h1, 64'h0, 64'h00000000FFFFFFFF);
        req(3'd0, 8'h1B, 40'h18, 2'b11, 8'h00, 64'h0, 64'h0, 64'h5);
        req(3'd0, 8'h1C, 40'h18, 2'b10, 8'h00, 64'h0, 64'h0, 64'h5);
        req(3'd0, 8'h1D, 40'h98, 2'b01, 8'h00, 64'h0, 64'h0, 64'h5);
        req(3'd1, 8'h20, 40'h20, 2'b11, 8'hFF, 64'h7, 64'h0, 64'h0);
        req(3'd4, 8'h21, 40'h20, 2'b11, 8'h00, 64'h7, 64'h9, 64'h7);
        req(3'd4, 8'h22, 40'h20, 2'b11, 8'h00, 64'h7, 64'h9, 64'h9);
        req(3'd0, 8'h23, 40'h20, 2'b11, 8'h00, 64'h0, 64'h0, 64'h9);
        req(3'd6, 8'h24, 40'h20, 2'b11, 8'hFF, 64'h1234, 64'h0, 64'hFFFFFFFFFFFFFFFF);
        req(3'd7, 8'h25, 40'h20, 2'b11, 8'hFF, 64'h1234, 64'h1234, 64'hFFFFFFFFFFFFFFFF);
        req(3'd0, 8'h26, 40'h20, 2'b11, 8'h00, 64'h0, 64'h0, 64'h9);
        drain();

        last = -1;
        pulses = 0;
        mem_req_req_type = 3'd0; mem_req_address = 40'h20; mem_req_size = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_req_mshrid = 8'h40 + 8'(i);
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
                if (last >= 0) chk("ready_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                pulses++;
                q.push_back('{id: mem_req_mshrid, data: 64'h9, due: cyc + 3});
            end
        end
        chk("ready_pulses", 64'(pulses), 64'd5);
        @(posedge clk);
        #1 mem_req_valid = 1'b0;
        drain();

        @(negedge clk);
        mem_req_req_type = 3'd1; mem_req_mshrid = 8'h77; mem_req_address = 40'h30;
        mem_req_write_mask = 8'hFF; mem_req_data_0 = 64'hCAFE; mem_req_valid = 1'b1;
        @(posedge clk);
        #1 mem_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_exec", {63'h0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'h0, mem_req_ready}, 64'd1);
        chk("midrst_busy", {63'h0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", {63'h0, mem_req_ready}, 64'd1);
        chk("post_rst_mshrid", {56'h0, atomic_resp_mshrid}, 64'd0);
        req(3'd0, 8'h78, 40'h30, 2'b11, 8'h00, 64'h0, 64'h0, 64'h0);
        req(3'd0, 8'h79, 40'h20, 2'b11, 8'h00, 64'h0, 64'h0, 64'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
